// File: rtl/bcla_serial_word_adder.sv
// Byte-serial multi-word adder: one 8-bit carry look-ahead slice plus a carry register chained across bytes.
// One-cycle latency; single output register, in_ready drops while a held output is not taken.
module bcla_serial_word_adder #(
  parameter int MAX_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_cout,
  output logic       out_err
);

  localparam int CW = $clog2(MAX_BYTES) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            vld_q, vld_d;
  logic [7:0]      sum_q, sum_d;
  logic            last_q, last_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic            accept;
  logic            at_limit;
  logic            ends_word;
  logic [7:0]      gen, prop;
  logic [8:0]      c;
  logic [7:0]      slice_sum;

  // 8-bit block carry look-ahead slice
  assign gen  = in_x & in_y;
  assign prop = in_x ^ in_y;

  always_comb begin
    c    = '0;
    c[0] = carry_q;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = gen[i] | (prop[i] & c[i]);
    end
    slice_sum = prop ^ c[7:0];
  end

  assign at_limit  = (cnt_q == CW'(MAX_BYTES - 1));
  assign ends_word = in_last || at_limit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (ends_word) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // Output / datapath logic
  always_comb begin
    in_ready = !vld_q || out_ready;
    accept   = in_valid && in_ready;

    carry_d = carry_q;
    vld_d   = vld_q;
    sum_d   = sum_q;
    last_d  = last_q;
    cout_d  = cout_q;
    err_d   = err_q;

    if (accept) begin
      vld_d  = 1'b1;
      sum_d  = slice_sum;
      last_d = ends_word;
      err_d  = ends_word && !in_last;
      if (ends_word) begin
        carry_d = 1'b0;
        cout_d  = c[8];
      end else begin
        carry_d = c[8];
        cout_d  = 1'b0;
      end
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_last  = last_q;
  assign out_cout  = cout_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_bcla_serial_word_adder.sv
// Directed self-checking bench for bcla_serial_word_adder with MAX_BYTES=4.
module tb_bcla_serial_word_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_last;
  logic       out_cout;
  logic       out_err;

  int pass_cnt = 0;
  int total    = 0;

  bcla_serial_word_adder #(.MAX_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic l);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    in_last  = l;
  endtask

  // Checks one emitted byte: valid, sum, last, cout, err
  task automatic expect_out(input string tag, input logic [7:0] s, input logic l,
                            input logic co, input logic e);
    check({tag, "_vld"},  out_valid, 1'b1);
    check({tag, "_sum"},  out_sum,   s);
    check({tag, "_last"}, out_last,  l);
    check({tag, "_cout"}, out_cout,  co);
    check({tag, "_err"},  out_err,   e);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'hAA, 8'h55, 1'b1);
    step();
    check("rst_vld",   out_valid, 1'b0);
    check("rst_sum",   out_sum,   8'h00);
    check("rst_last",  out_last,  1'b0);
    check("rst_cout",  out_cout,  1'b0);
    check("rst_err",   out_err,   1'b0);
    check("rst_ready", in_ready,  1'b1);
    rst = 1'b0;

    // Reset mid-word drops the pending carry
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    step();
    expect_out("mid_b0", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    step();
    check("mid_rst_vld", out_valid, 1'b0);
    rst = 1'b0;
    drive(1'b1, 8'h10, 8'h20, 1'b1);
    step();
    expect_out("mid_fresh", 8'h30, 1'b1, 1'b0, 1'b0);

    // 0xFFFFFFFF + 0x00000001
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    step();
    expect_out("w32_b0", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 8'h00, 1'b0);
    step();
    expect_out("w32_b1", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("w32_b2", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 8'h00, 1'b1);
    step();
    expect_out("w32_b3", 8'h00, 1'b1, 1'b1, 1'b0);

    // Carry must not leak from word A into word B
    drive(1'b1, 8'h80, 8'h80, 1'b1);
    step();
    expect_out("isoA", 8'h00, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h01, 8'h01, 1'b1);
    step();
    expect_out("isoB", 8'h02, 1'b1, 1'b0, 1'b0);

    // Idle input values must not disturb anything
    drive(1'b0, 8'hFF, 8'hFF, 1'b0);
    step();
    check("idle_vld", out_valid, 1'b0);

    // Backpressure on 0x12FF + 0x0001
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    step();
    expect_out("bp_b0", 8'h00, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 8'h12, 8'h00, 1'b1);
    #1;
    check("bp_ready0", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("bp_hold", 8'h00, 1'b0, 1'b0, 1'b0);
      check("bp_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready1", in_ready, 1'b1);
    step();
    expect_out("bp_b1", 8'h13, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    step();
    check("bp_drain_vld", out_valid, 1'b0);

    // Truncation at four bytes
    drive(1'b1, 8'h01, 8'h01, 1'b0);
    step();
    expect_out("tr_b1", 8'h02, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("tr_b2", 8'h02, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("tr_b3", 8'h02, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("tr_b4", 8'h02, 1'b1, 1'b0, 1'b1);
    step();
    expect_out("tr_b5", 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hF0, 8'h20, 1'b1);
    step();
    expect_out("tr_b6", 8'h10, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    step();
    check("end_vld", out_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
